// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the stopwatch sequencer and its surroundings (buttons, mode
// switch, digit chain). The slave side is the sequencer; the master side drives its inputs.
interface stopwatch_ctrl_if;
  // No valid/ready handshake: cnt_en, clr and lap_pulse are single-cycle strobes that
  // every digit consumes on the edge they are high. All other outputs are levels.
  logic       btn_ss;
  logic       btn_lap;
  logic       mode_up;
  logic       chain_zero;
  logic       cnt_en;
  logic       dir;
  logic       clr;
  logic       lap_pulse;
  logic       lap_view;
  logic       alarm;
  logic [1:0] state;

  modport slave (
    input  btn_ss, btn_lap, mode_up, chain_zero,
    output cnt_en, dir, clr, lap_pulse, lap_view, alarm, state
  );

  modport master (
    output btn_ss, btn_lap, mode_up, chain_zero,
    input  cnt_en, dir, clr, lap_pulse, lap_view, alarm, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch/timer sequencer: button sync + debounce, main FSM, count-tick prescaler.
// Optional macro ALARM_BLINK_EN makes the expiry alarm blink at 1 Hz instead of staying high.
module stopwatch_ctrl #(
  parameter int CLK_HZ          = 100000000,
  parameter int TICK_HZ         = 100,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk100MHz,
  input  logic             rst,
  stopwatch_ctrl_if.slave  bus
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_PAUSE   = 2'd2;
  localparam logic [1:0] S_EXPIRED = 2'd3;

  // bit 0 = start/stop, bit 1 = lap/reset
  logic [1:0]         w_raw;
  logic [1:0]         r_meta;
  logic [1:0]         r_sync;
  logic [1:0]         r_lvl;
  logic [1:0][DW-1:0] r_db_cnt;
  logic [1:0]         w_press;
  logic               w_ss;
  logic               w_lap;

  logic [1:0]    r_state;
  logic          r_dir;
  logic          r_lap_view;
  logic          r_alarm;
  logic          r_cnt_en;
  logic          r_clr;
  logic          r_lap_pulse;
  logic [PW-1:0] r_presc;

  logic [1:0] w_state_nxt;
  logic       w_dir_nxt;
  logic       w_lap_view_nxt;
  logic       w_alarm_nxt;
  logic       w_cnt_en_nxt;
  logic       w_clr_nxt;
  logic       w_lap_pulse_nxt;
  logic       w_tick;
  logic       w_start_ok;
  logic       w_presc_run;

  assign w_raw = {bus.btn_lap, bus.btn_ss};

  always_ff @(posedge clk100MHz or negedge rst) begin
    if (!rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= w_raw;
      r_sync <= r_meta;
    end
  end

  // The counter measures how long the synchronized level has disagreed with the
  // accepted level; any agreeing sample restarts the count.
  always_ff @(posedge clk100MHz or negedge rst) begin
    if (!rst) begin
      r_lvl    <= '0;
      r_db_cnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_sync[i] == r_lvl[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DEB_LAST) begin
          r_lvl[i]    <= r_sync[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_press[0] = (r_sync[0] != r_lvl[0]) && (r_db_cnt[0] == DEB_LAST) && r_sync[0];
  assign w_press[1] = (r_sync[1] != r_lvl[1]) && (r_db_cnt[1] == DEB_LAST) && r_sync[1];
  assign w_ss       = w_press[0];
  assign w_lap      = w_press[1] && !w_press[0];

  // Starting a countdown that is already at zero would expire instantly, so refuse it.
  assign w_start_ok = bus.mode_up || !bus.chain_zero;
  assign w_tick     = (r_presc == PRESC_LAST);

`ifdef ALARM_BLINK_EN
  localparam int BLINK_TICKS = (TICK_HZ / 2 > 0) ? TICK_HZ / 2 : 1;
  localparam int BW          = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  logic [BW-1:0] r_blink_cnt;
  logic          w_blink_toggle;

  assign w_blink_toggle = (r_state == S_EXPIRED) && w_tick && (r_blink_cnt == BLINK_LAST);

  always_ff @(posedge clk100MHz or negedge rst) begin
    if (!rst) begin
      r_blink_cnt <= '0;
    end else if (r_state != S_EXPIRED || w_state_nxt != S_EXPIRED) begin
      r_blink_cnt <= '0;
    end else if (w_tick) begin
      r_blink_cnt <= (r_blink_cnt == BLINK_LAST) ? '0 : r_blink_cnt + 1'b1;
    end
  end

  assign w_presc_run = ((r_state == S_RUN) && (w_state_nxt == S_RUN)) ||
                       ((r_state == S_EXPIRED) && (w_state_nxt == S_EXPIRED));
`else
  assign w_presc_run = (r_state == S_RUN) && (w_state_nxt == S_RUN);
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_dir_nxt       = r_dir;
    w_lap_view_nxt  = r_lap_view;
    w_alarm_nxt     = r_alarm;
    w_cnt_en_nxt    = 1'b0;
    w_clr_nxt       = 1'b0;
    w_lap_pulse_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ss && w_start_ok) begin
          w_state_nxt = S_RUN;
          w_dir_nxt   = bus.mode_up;
        end
      end
      S_RUN: begin
        // Reaching zero while counting down outranks a simultaneous start/stop press.
        if (!r_dir && bus.chain_zero) begin
          w_state_nxt = S_EXPIRED;
          w_alarm_nxt = 1'b1;
        end else begin
          w_cnt_en_nxt = w_tick;
          if (w_ss) begin
            w_state_nxt = S_PAUSE;
          end else if (w_lap && r_dir) begin
            w_lap_pulse_nxt = 1'b1;
            w_lap_view_nxt  = 1'b1;
          end
        end
      end
      S_PAUSE: begin
        if (w_ss) begin
          if (w_start_ok) begin
            w_state_nxt = S_RUN;
            w_dir_nxt   = bus.mode_up;
          end
        end else if (w_lap) begin
          w_state_nxt    = S_IDLE;
          w_clr_nxt      = 1'b1;
          w_lap_view_nxt = 1'b0;
        end
      end
      S_EXPIRED: begin
        if (w_press != 2'b00) begin
          w_state_nxt    = S_IDLE;
          w_clr_nxt      = 1'b1;
          w_alarm_nxt    = 1'b0;
          w_lap_view_nxt = 1'b0;
        end
`ifdef ALARM_BLINK_EN
        else if (w_blink_toggle) begin
          w_alarm_nxt = !r_alarm;
        end
`endif
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk100MHz or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
    end else if (w_presc_run) begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
    end else begin
      r_presc <= '0;
    end
  end

  always_ff @(posedge clk100MHz or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_dir       <= 1'b1;
      r_lap_view  <= 1'b0;
      r_alarm     <= 1'b0;
      r_cnt_en    <= 1'b0;
      r_clr       <= 1'b0;
      r_lap_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_dir       <= w_dir_nxt;
      r_lap_view  <= w_lap_view_nxt;
      r_alarm     <= w_alarm_nxt;
      r_cnt_en    <= w_cnt_en_nxt;
      r_clr       <= w_clr_nxt;
      r_lap_pulse <= w_lap_pulse_nxt;
    end
  end

  assign bus.state     = r_state;
  assign bus.dir       = r_dir;
  assign bus.lap_view  = r_lap_view;
  assign bus.alarm     = r_alarm;
  assign bus.cnt_en    = r_cnt_en;
  assign bus.clr       = r_clr;
  assign bus.lap_pulse = r_lap_pulse;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed test-plan sequences plus random button activity,
// checked event-by-event against a cycle-stamped reference model.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stopwatch_ctrl_if bus ();

  stopwatch_ctrl #(
    .CLK_HZ          (1000),
    .TICK_HZ         (100),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk100MHz (clk),
    .rst       (rst_n),
    .bus       (bus)
  );

  localparam logic [7:0] RESET_VEC = 8'b0010_0000;

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc   = 0;
  bit          mon_on = 1'b0;
  // record = {cycle[23:0], state[1:0], dir, lap_view, alarm, cnt_en, clr, lap_pulse}
  logic [31:0] exp_q[$];
  logic [7:0]  mon_last = RESET_VEC;

  logic [1:0] m_state;
  bit         m_dir, m_lv, m_alarm, m_lvl_ss, m_lvl_lap;
  int         m_run;
  logic [7:0] hs_ss, hs_lap;
  logic [7:0] m_last   = RESET_VEC;
  logic [7:0] m_before = RESET_VEC;

  function automatic logic [7:0] dut_vec();
    return {bus.state, bus.dir, bus.lap_view, bus.alarm, bus.cnt_en, bus.clr, bus.lap_pulse};
  endfunction

  task automatic check1(input string nm, input logic [7:0] got, input logic [7:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s got=%b required=%b", nm, got, req);
    end
  endtask

  task automatic model_reset();
    hs_ss = '0; hs_lap = '0; m_lvl_ss = 0; m_lvl_lap = 0;
    m_state = 2'd0; m_dir = 1; m_lv = 0; m_alarm = 0; m_run = 0;
    // an event produced on this edge is wiped by the reset before it can be seen
    if (exp_q.size() > 0 && exp_q[$][31:8] == cyc[23:0]) begin
      void'(exp_q.pop_back());
      m_last = m_before;
    end
    if (RESET_VEC != m_last) exp_q.push_back({cyc[23:0], RESET_VEC});
    m_last = RESET_VEC;
  endtask

  // One rising edge of the reference: window-based button acceptance, then state rules.
  task automatic model_step();
    bit p_ss, p_lap, ce, cl, lp, ok;
    logic [7:0] v;
    cyc++;
    m_before = m_last;
    if (!rst_n) return;
    hs_ss  = {hs_ss[6:0], bus.btn_ss};
    hs_lap = {hs_lap[6:0], bus.btn_lap};
    p_ss = 0; p_lap = 0; ce = 0; cl = 0; lp = 0;
    if (hs_ss[5:2] == {4{~m_lvl_ss}}) begin m_lvl_ss = ~m_lvl_ss; p_ss = m_lvl_ss; end
    if (hs_lap[5:2] == {4{~m_lvl_lap}}) begin m_lvl_lap = ~m_lvl_lap; p_lap = m_lvl_lap; end
    if (p_ss) p_lap = 0;
    ok = bus.mode_up || !bus.chain_zero;
    case (m_state)
      2'd0: if (p_ss && ok) begin m_state = 2'd1; m_dir = bus.mode_up; m_run = 0; end
      2'd1: begin
        m_run++;
        if (!m_dir && bus.chain_zero) begin
          m_state = 2'd3; m_alarm = 1;
        end else begin
          ce = (m_run % 10 == 0);
          if (p_ss) m_state = 2'd2;
          else if (p_lap && m_dir) begin lp = 1; m_lv = 1; end
        end
      end
      2'd2: begin
        if (p_ss) begin
          if (ok) begin m_state = 2'd1; m_dir = bus.mode_up; m_run = 0; end
        end else if (p_lap) begin
          m_state = 2'd0; cl = 1; m_lv = 0;
        end
      end
      default: if (p_ss || p_lap) begin m_state = 2'd0; cl = 1; m_alarm = 0; m_lv = 0; end
    endcase
    v = {m_state, m_dir, m_lv, m_alarm, ce, cl, lp};
    if (v != m_last || ce || cl || lp) exp_q.push_back({cyc[23:0], v});
    m_last = v;
  endtask

  always @(negedge clk) begin
    logic [7:0]  v;
    logic [31:0] e;
    if (mon_on) begin
      v = dut_vec();
      if (v != mon_last || (|v[2:0])) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_event got cyc=%0d vec=%b required no event", cyc, v);
        end else begin
          e = exp_q.pop_front();
          if ({cyc[23:0], v} !== e) begin
            n_bad++;
            $display("FAIL output_event got cyc=%0d vec=%b required cyc=%0d vec=%b",
                     cyc, v, e[31:8], e[7:0]);
          end
        end
      end
      mon_last = v;
    end
  end

  task automatic cyc_step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic press(input bit ss, input bit lap, input int hold, input int gap);
    if (ss)  bus.btn_ss  = 1'b1;
    if (lap) bus.btn_lap = 1'b1;
    repeat (hold) cyc_step();
    bus.btn_ss  = 1'b0;
    bus.btn_lap = 1'b0;
    repeat (gap) cyc_step();
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget);
    int n = 0;
    while (m_state != s && n < budget) begin cyc_step(); n++; end
    if (m_state != s) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_state got=%0d required=%0d", m_state, s);
    end
    check1("state_probe", {6'b0, bus.state}, {6'b0, m_state});
  endtask

  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    model_reset();
    #1;
    check1("reset_values", dut_vec(), RESET_VEC);
    repeat (hold) cyc_step();
    check1("reset_held", dut_vec(), RESET_VEC);
    rst_n = 1'b1;
  endtask

  initial begin
    int r;
    rst_n = 1'b1;
    bus.btn_ss = 0; bus.btn_lap = 0; bus.mode_up = 1; bus.chain_zero = 0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check1("reset_values", dut_vec(), RESET_VEC);
    mon_on = 1'b1;
    repeat (3) cyc_step();
    rst_n = 1'b1;
    repeat (3) cyc_step();

    // 1: clean start, count up, several ticks
    press(1, 0, 8, 40);
    wait_state(2'd1, 20);
    // 3: lap in RUN up, pause, lap clears
    press(0, 1, 6, 12);
    press(1, 0, 6, 25);
    wait_state(2'd2, 20);
    press(0, 1, 6, 12);
    wait_state(2'd0, 20);
    // 2: bouncing start button
    repeat (10) begin bus.btn_ss = ~bus.btn_ss; cyc_step(); cyc_step(); end
    bus.btn_ss = 1'b1;
    repeat (10) cyc_step();
    bus.btn_ss = 1'b0;
    repeat (15) cyc_step();
    wait_state(2'd1, 20);
    // 4: pause, restart counting down, reach zero, expire, clear
    press(1, 0, 6, 12);
    wait_state(2'd2, 20);
    bus.mode_up = 0; bus.chain_zero = 0;
    press(1, 0, 6, 30);
    wait_state(2'd1, 20);
    bus.chain_zero = 1;
    repeat (15) cyc_step();
    wait_state(2'd3, 20);
    press(0, 1, 6, 12);
    wait_state(2'd0, 20);
    // 5: zero-countdown start refused; simultaneous presses in RUN
    press(1, 0, 6, 15);
    check1("zero_start_ignored", {6'b0, bus.state}, 8'd0);
    bus.mode_up = 1; bus.chain_zero = 0;
    press(1, 0, 6, 23);
    press(1, 1, 6, 15);
    wait_state(2'd2, 20);
    // 6: reset mid-prescale, then a fresh start
    press(1, 0, 6, 0);
    wait_state(2'd1, 20);
    repeat (6) cyc_step();
    do_reset(2);
    repeat (3) cyc_step();
    press(1, 0, 6, 35);

    // random activity
    for (int k = 0; k < 80; k++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: press(1, 0, $urandom_range(1, 12), $urandom_range(6, 20));
        4, 5:       press(0, 1, $urandom_range(1, 12), $urandom_range(6, 20));
        6:          press(1, 1, $urandom_range(3, 10), $urandom_range(6, 20));
        7:          begin bus.mode_up = 1'($urandom_range(0, 1)); cyc_step(); end
        8:          begin bus.chain_zero = ($urandom_range(0, 3) == 0); cyc_step(); end
        default:    repeat ($urandom_range(1, 40)) cyc_step();
      endcase
    end

    repeat (30) cyc_step();
    #10;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL pending_events got=%0d outstanding required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
